// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the M-extension multiply/divide unit.
package riscv_pkg;

  // M-extension funct3 encodings
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } muldiv_state_t;

  // funct7 value that selects the M-extension in the OP opcode space
  localparam logic [6:0] Funct7Muldiv = 7'b0000001;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation.
module muldiv_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + WIDTH'(1)) : data_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with start/done handshake.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  muldiv_state_t     state_q, state_d;
  muldiv_op_t        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  // ---------------------------------------------------------------------------
  // Operand preparation on the incoming request
  // ---------------------------------------------------------------------------
  muldiv_op_t      op_in;
  logic            sign_a, sign_b, neg_in;
  logic            is_div_in, is_rem_in, signed_div_in;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  assign op_in         = muldiv_op_t'(funct3);
  assign is_div_in     = op_in inside {OpDiv, OpDivu, OpRem, OpRemu};
  assign is_rem_in     = op_in inside {OpRem, OpRemu};
  assign signed_div_in = op_in inside {OpDiv, OpRem};
  assign sign_a        = a[XLEN-1] & (op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem});
  assign sign_b        = b[XLEN-1] & (op_in inside {OpMulh, OpDiv, OpRem});
  // Remainder takes the dividend's sign; product and quotient the XOR
  assign neg_in        = is_rem_in ? sign_a : (sign_a ^ sign_b);

  assign div_zero = is_div_in && (b == '0);
  assign div_ovf  = signed_div_in && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign fast     = div_zero || div_ovf;

  // Divide-by-zero wins over overflow (b cannot be both zero and -1 anyway)
  always_comb begin
    if (div_zero) fast_res = is_rem_in ? a : '1;
    else          fast_res = is_rem_in ? '0 : a;
  end

  muldiv_negate #(.WIDTH(XLEN)) u_neg_a (
    .data_i (a),
    .neg_i  (sign_a),
    .data_o (mag_a)
  );

  muldiv_negate #(.WIDTH(XLEN)) u_neg_b (
    .data_i (b),
    .neg_i  (sign_b),
    .data_o (mag_b)
  );

  // ---------------------------------------------------------------------------
  // One iteration step of the running operation
  // ---------------------------------------------------------------------------
  logic              is_div_q, is_rem_q;
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step;

  assign is_div_q = op_q inside {OpDiv, OpDivu, OpRem, OpRemu};
  assign is_rem_q = op_q inside {OpRem, OpRemu};

  // Multiply: multiplier in the low half shifts out, partial sum in the high half.
  // Divide: {remainder, quotient} shifts left, restoring subtraction on the top.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, opb_q};
    if (div_diff[XLEN]) div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step = is_div_q ? div_next : mul_next;
  end

  // ---------------------------------------------------------------------------
  // Sign fixup of the final step. A quotient/remainder is zero-extended so the
  // low half of the wide negation is its XLEN-bit two's complement.
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    if (!is_div_q)     fix_in = step;
    else if (is_rem_q) fix_in = {{XLEN{1'b0}}, step[2*XLEN-1:XLEN]};
    else               fix_in = {{XLEN{1'b0}}, step[XLEN-1:0]};
  end

  muldiv_negate #(.WIDTH(2*XLEN)) u_neg_res (
    .data_i (fix_in),
    .neg_i  (neg_q),
    .data_o (fix_out)
  );

  assign final_res = (op_q == OpMul || is_div_q) ? fix_out[XLEN-1:0]
                                                 : fix_out[2*XLEN-1:XLEN];

  // ---------------------------------------------------------------------------
  // FSM next-state: kill beats start; start only sampled in IDLE/DONE
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (kill) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StCalc: begin
          acc_d = step;
          if (cnt_q == '0) begin
            state_d  = StDone;
            result_d = final_res;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: begin
          if (start) begin
            op_d  = op_in;
            cnt_d = CntW'(XLEN - 1);
            acc_d = {{XLEN{1'b0}}, mag_a};
            opb_d = mag_b;
            neg_d = neg_in;
            if (fast) begin
              state_d  = StDone;
              result_d = fast_res;
            end else begin
              state_d = StCalc;
            end
          end else begin
            state_d = StIdle;
          end
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == StCalc);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule
